// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin grant, one SETUP/ACCESS transfer at a time,
// slave select from the address MSB, and a wait-state timeout that aborts a stuck transfer.
module apb_arb_master #(
  parameter int ADD_WIDTH = 9,
  parameter int WIDTH     = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 pclk,
  input  logic                 preset,

  input  logic                 req0_valid,
  input  logic                 req0_write,
  input  logic [ADD_WIDTH-1:0] req0_addr,
  input  logic [WIDTH-1:0]     req0_wdata,
  input  logic [WIDTH/8-1:0]   req0_strb,
  output logic                 req0_done,
  output logic [WIDTH-1:0]     req0_rdata,
  output logic                 req0_err,

  input  logic                 req1_valid,
  input  logic                 req1_write,
  input  logic [ADD_WIDTH-1:0] req1_addr,
  input  logic [WIDTH-1:0]     req1_wdata,
  input  logic [WIDTH/8-1:0]   req1_strb,
  output logic                 req1_done,
  output logic [WIDTH-1:0]     req1_rdata,
  output logic                 req1_err,

  output logic                 psel1,
  output logic                 psel2,
  output logic                 penable,
  output logic                 pwrite,
  output logic [ADD_WIDTH-1:0] paddr,
  output logic [WIDTH-1:0]     pwdata,
  output logic [WIDTH/8-1:0]   pstrb,
  input  logic                 pready,
  input  logic [WIDTH-1:0]     prdata,
  input  logic                 pslverr
);

  // state  | meaning
  // IDLE   | no transfer in flight; arbitrate eligible requests
  // SETUP  | first APB phase: psel high, penable low
  // ACCESS | penable high; wait for pready or the timeout

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                 last_grant;
  logic                 grant;
  logic                 win;
  logic                 start;
  logic                 xfer_ok;
  logic                 xfer_abort;
  logic                 xfer_end;
  logic                 elig0;
  logic                 elig1;
  logic                 err_nxt;
  logic [WIDTH-1:0]     rdata_nxt;

  logic                 cap_write;
  logic [ADD_WIDTH-1:0] cap_addr;
  logic [WIDTH-1:0]     cap_wdata;
  logic [WIDTH/8-1:0]   cap_strb;
  logic [CW-1:0]        wait_cnt;

  // A requester whose done pulse is showing is masked so its still-high valid
  // is not mistaken for a new request.
  assign elig0 = req0_valid & ~req0_done;
  assign elig1 = req1_valid & ~req1_done;

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    win        = 1'b0;
    xfer_ok    = 1'b0;
    xfer_abort = 1'b0;
    case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          start     = 1'b1;
          win       = (elig0 & elig1) ? ~last_grant : elig1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          xfer_ok   = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          xfer_abort = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign xfer_end  = xfer_ok | xfer_abort;
  assign err_nxt   = xfer_abort | pslverr;
  assign rdata_nxt = (xfer_ok & ~cap_write) ? prdata : '0;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      wait_cnt   <= '0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_strb   <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        grant      <= win;
        last_grant <= win;
        cap_write  <= win ? req1_write : req0_write;
        cap_addr   <= win ? req1_addr  : req0_addr;
        cap_wdata  <= win ? req1_wdata : req0_wdata;
        cap_strb   <= win ? req1_strb  : req0_strb;
        wait_cnt   <= '0;
      end else if (state == ACCESS) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  // Completion results live for exactly one cycle, then return to zero.
  always_ff @(posedge pclk) begin
    if (preset) begin
      req0_done  <= 1'b0;
      req0_err   <= 1'b0;
      req0_rdata <= '0;
      req1_done  <= 1'b0;
      req1_err   <= 1'b0;
      req1_rdata <= '0;
    end else begin
      req0_done  <= xfer_end & ~grant;
      req0_err   <= xfer_end & ~grant & err_nxt;
      req0_rdata <= (xfer_end & ~grant) ? rdata_nxt : '0;
      req1_done  <= xfer_end & grant;
      req1_err   <= xfer_end & grant & err_nxt;
      req1_rdata <= (xfer_end & grant) ? rdata_nxt : '0;
    end
  end

  // Address, data and direction hold their last values between transfers.
  assign psel1   = (state != IDLE) & ~cap_addr[ADD_WIDTH-1];
  assign psel2   = (state != IDLE) &  cap_addr[ADD_WIDTH-1];
  assign penable = (state == ACCESS);
  assign pwrite  = cap_write;
  assign paddr   = cap_addr;
  assign pwdata  = cap_wdata;
  assign pstrb   = ((state != IDLE) & cap_write) ? cap_strb : '0;

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: transaction-level reference model compared every cycle,
// directed scenarios with hand-computed expectations, and a reactive APB slave.
module tb_apb_arb_master;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int TO = 16;

  logic pclk = 1'b0;
  logic preset = 1'b1;

  logic          rv  [2];
  logic          rw  [2];
  logic [AW-1:0] ra  [2];
  logic [DW-1:0] rwd [2];
  logic [3:0]    rsb [2];

  wire          d0, d1, er0, er1;
  wire [DW-1:0] rd0, rd1;
  wire          psel1, psel2, penable, pwrite;
  wire [AW-1:0] paddr;
  wire [DW-1:0] pwdata;
  wire [3:0]    pstrb;

  logic          pready  = 1'b0;
  logic [DW-1:0] prdata  = '0;
  logic          pslverr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  always #5 pclk = ~pclk;

  apb_arb_master #(.ADD_WIDTH(AW), .WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .req0_valid(rv[0]), .req0_write(rw[0]), .req0_addr(ra[0]), .req0_wdata(rwd[0]),
    .req0_strb(rsb[0]), .req0_done(d0), .req0_rdata(rd0), .req0_err(er0),
    .req1_valid(rv[1]), .req1_write(rw[1]), .req1_addr(ra[1]), .req1_wdata(rwd[1]),
    .req1_strb(rsb[1]), .req1_done(d1), .req1_rdata(rd1), .req1_err(er1),
    .psel1(psel1), .psel2(psel2), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Reactive slave: ready after slave_waits ACCESS cycles unless stuck.
  int            slave_waits = 0;
  logic          slave_stuck = 1'b0;
  logic          slave_err   = 1'b0;
  logic [DW-1:0] slave_data  = 32'hDEAD_BEEF;
  int            acc_n       = 0;

  always @(negedge pclk) begin
    if (penable) begin
      pready  <= !slave_stuck && (acc_n >= slave_waits);
      prdata  <= slave_data;
      pslverr <= slave_err;
      acc_n   <= acc_n + 1;
    end else begin
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
      acc_n   <= 0;
    end
  end

  // Reference model: a transfer is "busy" for m_cyc cycles since its grant
  // (1 = setup phase, 2.. = access phase); completion is reported next cycle.
  logic          m_busy, m_who, m_last, m_wr;
  int            m_cyc;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [3:0]    m_sb;
  logic [1:0]    m_done, m_err;
  logic [DW-1:0] m_rd [2];

  wire m_e0  = rv[0] && !m_done[0];
  wire m_e1  = rv[1] && !m_done[1];
  wire m_win = (m_e0 && m_e1) ? !m_last : m_e1;
  wire m_to  = (m_cyc - 2 == TO - 1);

  always @(posedge pclk) begin
    m_done   <= 2'b00;
    m_err    <= 2'b00;
    m_rd[0]  <= '0;
    m_rd[1]  <= '0;
    if (preset) begin
      m_busy <= 1'b0; m_cyc <= 0; m_last <= 1'b1; m_who <= 1'b0;
      m_wr <= 1'b0; m_addr <= '0; m_wd <= '0; m_sb <= '0;
    end else if (!m_busy) begin
      if (m_e0 || m_e1) begin
        m_busy <= 1'b1; m_cyc <= 1; m_who <= m_win; m_last <= m_win;
        m_wr <= rw[m_win]; m_addr <= ra[m_win]; m_wd <= rwd[m_win]; m_sb <= rsb[m_win];
      end
    end else if (m_cyc == 1) begin
      m_cyc <= 2;
    end else if (pready || m_to) begin
      m_busy         <= 1'b0;
      m_done[m_who]  <= 1'b1;
      m_err[m_who]   <= pready ? pslverr : 1'b1;
      m_rd[m_who]    <= (pready && !m_wr) ? prdata : '0;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge pclk) begin
    if (chk_en) begin
      check("psel1",   psel1,   m_busy && !m_addr[AW-1]);
      check("psel2",   psel2,   m_busy &&  m_addr[AW-1]);
      check("penable", penable, m_busy && m_cyc >= 2);
      check("pwrite",  pwrite,  m_wr);
      check("paddr",   paddr,   m_addr);
      check("pwdata",  pwdata,  m_wd);
      check("pstrb",   pstrb,   (m_busy && m_wr) ? m_sb : 4'h0);
      check("req0_done",  d0,  m_done[0]);
      check("req0_err",   er0, m_err[0]);
      check("req0_rdata", rd0, m_rd[0]);
      check("req1_done",  d1,  m_done[1]);
      check("req1_err",   er1, m_err[1]);
      check("req1_rdata", rd1, m_rd[1]);
    end
  end

  int order[$];
  always @(negedge pclk) begin
    if (chk_en) begin
      if (d0) order.push_back(0);
      if (d1) order.push_back(1);
    end
  end

  task automatic do_req(input int n, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [3:0] sb,
                        output logic [DW-1:0] rd, output logic er, output int pen,
                        output int lat, output logic s1, output logic s2);
    logic got;
    rw[n] = wr; ra[n] = a; rwd[n] = wd; rsb[n] = sb; rv[n] = 1'b1;
    pen = 0; lat = 0; s1 = 1'b0; s2 = 1'b0; rd = '0; er = 1'b0; got = 1'b0;
    do begin
      step();
      lat++;
      if (penable) pen++;
      if (psel1) s1 = 1'b1;
      if (psel2) s2 = 1'b1;
      got = (n == 0) ? d0 : d1;
    end while (!got && lat < 60);
    check("request completed within bound", got, 1'b1);
    rd = (n == 0) ? rd0 : rd1;
    er = (n == 0) ? er0 : er1;
    rv[n] = 1'b0;
  endtask

  // Back-to-back requester: keeps valid high and presents a new request in its done cycle.
  task automatic agent(input int n);
    int w;
    logic got;
    for (int k = 0; k < 2; k++) begin
      rw[n]  = (k == n);
      ra[n]  = ((n == 0) ? 9'h020 : 9'h140) + 9'(k);
      rwd[n] = 32'hC0DE_0000 + 32'(n * 16 + k);
      rsb[n] = (n == 0) ? 4'h3 : 4'hC;
      rv[n]  = 1'b1;
      w = 0;
      do begin
        step();
        w++;
        got = (n == 0) ? d0 : d1;
      end while (!got && w < 40);
      check("agent request completed", got, 1'b1);
    end
    rv[n] = 1'b0;
  endtask

  logic [DW-1:0] t_rd, u_rd;
  logic          t_er, t_s1, t_s2, u_er, u_s1, u_s2;
  int            t_pen, t_lat, u_pen, u_lat;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rwd[i] = '0; rsb[i] = '0;
    end
    preset = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    check("reset psel1", psel1, 1'b0);
    check("reset penable", penable, 1'b0);
    check("reset paddr", paddr, 9'h000);
    check("reset req0_done", d0, 1'b0);
    preset = 1'b0;
    step();

    // Test 1: zero-wait write from requester 0
    slave_waits = 0;
    rw[0] = 1'b1; ra[0] = 9'h005; rwd[0] = 32'hA5A5_A5A5; rsb[0] = 4'hF; rv[0] = 1'b1;
    t_s2 = 1'b0;
    step();
    t_s2 = t_s2 | psel2;
    check("t1 setup psel1", psel1, 1'b1);
    check("t1 setup penable", penable, 1'b0);
    step();
    t_s2 = t_s2 | psel2;
    check("t1 access penable", penable, 1'b1);
    check("t1 access pstrb", pstrb, 4'hF);
    check("t1 access pwdata", pwdata, 32'hA5A5_A5A5);
    step();
    t_s2 = t_s2 | psel2;
    check("t1 req0_done", d0, 1'b1);
    check("t1 req0_err", er0, 1'b0);
    check("t1 req0_rdata on write", rd0, 32'h0);
    check("t1 psel2 never high", t_s2, 1'b0);
    rv[0] = 1'b0;
    step();

    // Test 2: read from slave 2 with two wait states
    slave_waits = 2; slave_data = 32'h1234_5678;
    do_req(1, 1'b0, 9'h103, 32'h0, 4'hF, t_rd, t_er, t_pen, t_lat, t_s1, t_s2);
    check("t2 rdata", t_rd, 32'h1234_5678);
    check("t2 err", t_er, 1'b0);
    check("t2 penable cycles", t_pen, 3);
    check("t2 latency", t_lat, 5);
    check("t2 psel2 seen", t_s2, 1'b1);
    check("t2 psel1 never", t_s1, 1'b0);
    step();
    check("t2 rdata cleared", rd1, 32'h0);
    check("t2 done cleared", d1, 1'b0);

    // Test 3: both requesters back-to-back
    slave_waits = 0; slave_data = 32'h0BAD_F00D;
    preset = 1'b1;
    step();
    preset = 1'b0;
    order.delete();
    fork
      agent(0);
      agent(1);
    join
    step();
    check("t3 completion count", order.size(), 4);
    if (order.size() == 4) begin
      check("t3 order[0]", order[0], 0);
      check("t3 order[1]", order[1], 1);
      check("t3 order[2]", order[2], 0);
      check("t3 order[3]", order[3], 1);
    end

    // Test 4: timeout on requester 0, requester 1 waiting behind it
    slave_stuck = 1'b1; slave_data = 32'h5555_AAAA;
    fork
      begin
        do_req(0, 1'b0, 9'h010, 32'h0, 4'h0, t_rd, t_er, t_pen, t_lat, t_s1, t_s2);
        slave_stuck = 1'b0;
      end
      begin
        step();
        step();
        do_req(1, 1'b0, 9'h1AA, 32'h0, 4'h0, u_rd, u_er, u_pen, u_lat, u_s1, u_s2);
      end
    join
    check("t4 timeout err", t_er, 1'b1);
    check("t4 timeout rdata", t_rd, 32'h0);
    check("t4 access cycles", t_pen, 16);
    check("t4 latency", t_lat, 18);
    check("t4 req0 psel2 never", t_s2, 1'b0);
    check("t4 req1 err", u_er, 1'b0);
    check("t4 req1 rdata", u_rd, 32'h5555_AAAA);
    check("t4 req1 psel2", u_s2, 1'b1);
    step();

    // Test 5: slave error on a requester 1 write, then a clean requester 0 write
    slave_err = 1'b1;
    do_req(1, 1'b1, 9'h1FF, 32'hFEED_0001, 4'h6, t_rd, t_er, t_pen, t_lat, t_s1, t_s2);
    check("t5 slverr reported", t_er, 1'b1);
    check("t5 write rdata", t_rd, 32'h0);
    check("t5 psel2", t_s2, 1'b1);
    slave_err = 1'b0;
    do_req(0, 1'b1, 9'h0F0, 32'hFEED_0002, 4'h9, t_rd, t_er, t_pen, t_lat, t_s1, t_s2);
    check("t5 following err", t_er, 1'b0);
    check("t5 following latency", t_lat, 3);
    step();

    // Test 6: reset during ACCESS, then the still-valid request restarts
    rw[0] = 1'b1; ra[0] = 9'h044; rwd[0] = 32'h0000_6666; rsb[0] = 4'hF; rv[0] = 1'b1;
    step();
    step();
    check("t6 in access", penable, 1'b1);
    preset = 1'b1;
    step();
    check("t6 reset psel1", psel1, 1'b0);
    check("t6 reset penable", penable, 1'b0);
    check("t6 no done on abort", d0, 1'b0);
    preset = 1'b0;
    step();
    check("t6 restart psel1", psel1, 1'b1);
    check("t6 restart penable", penable, 1'b0);
    check("t6 still no done", d0, 1'b0);
    step();
    check("t6 restart access", penable, 1'b1);
    step();
    check("t6 restart done", d0, 1'b1);
    check("t6 restart err", er0, 1'b0);
    rv[0] = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_arb_master.md
Name: apb_arb_master

Overview:
- Two-requester APB master: round-robin arbitration between two internal request ports, then one APB transfer at a time (SETUP/ACCESS) to the two-slave bus.
- Sits in front of the slave fabric and shares the single APB master path between two clients.
- Slave select is decoded from the address MSB: 0 → slave 1, 1 → slave 2.
- Adds a wait-state timeout so a stuck slave cannot hang a requester.

Parameters:
ADD_WIDTH, 9, APB address width; bit ADD_WIDTH-1 selects the slave
WIDTH, 32, data width; strobe width is WIDTH/8
TIMEOUT, 16, maximum ACCESS cycles without pready before abort (≥2)

Ports:
pclk  in  1  clock, all logic on rising edge
preset  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 request; held with fields stable until req0_done
req0_write  in  1  1 = write, 0 = read
req0_addr  in  ADD_WIDTH  address
req0_wdata  in  WIDTH  write data
req0_strb  in  WIDTH/8  write byte strobes
req0_done  out  1  one-cycle completion pulse
req0_rdata  out  WIDTH  read data, valid with req0_done
req0_err  out  1  error flag, valid with req0_done
req1_*  same set and widths as req0_*, for requester 1
psel1  out  1  APB select, slave 1
psel2  out  1  APB select, slave 2
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADD_WIDTH  APB address
pwdata  out  WIDTH  APB write data
pstrb  out  WIDTH/8  APB strobes
pready  in  1  muxed slave ready
prdata  in  WIDTH  muxed slave read data
pslverr  in  1  muxed slave error

Behaviour:
- Reset (synchronous, preset=1 at a rising edge): FSM=IDLE; all outputs 0; wait counter 0; last_grant=1, so requester 0 wins the first tie.
- FSM states:
  - IDLE: evaluate eligible requests. Requester N is eligible if reqN_valid=1 and reqN_done=0 (the done mask stops re-granting a request whose valid is still high in its done cycle).
    - One eligible → grant it.
    - Both eligible → grant the requester ≠ last_grant.
    - On grant: capture write/addr/wdata/strb into registers, update last_grant, go to SETUP.
  - SETUP (1 cycle): psel1 = ~addr[MSB], psel2 = addr[MSB]; penable=0; paddr, pwrite, pwdata driven from the captured registers.
    - pstrb = captured strobe for writes, 0 for reads.
    - Go to ACCESS.
  - ACCESS: same psel, paddr, pwrite, pwdata, pstrb as SETUP; penable=1; wait counter increments each cycle.
    - pready=1: go to IDLE. Next cycle reqN_done=1 for the granted N; reqN_err=pslverr; reqN_rdata=prdata for reads, 0 for writes.
    - pready=0 with counter=TIMEOUT-1: abort, go to IDLE. Next cycle reqN_done=1, reqN_err=1, reqN_rdata=0.
    - Otherwise stay in ACCESS.
- Leaving ACCESS: psel, penable, pstrb return to 0 at the same edge. paddr, pwdata, pwrite hold their last values.
- Done/rdata/err are registered. done is a single-cycle pulse; rdata and err are cleared to 0 the cycle after done.
- Latency: valid seen in IDLE at cycle t → SETUP at t+1 → ACCESS at t+2 → (zero wait states) done at t+3. Each wait state adds one cycle.
- Throughput: one transfer per 3 cycles minimum (IDLE → SETUP → ACCESS).
- Requests arriving in SETUP or ACCESS are not lost; they are evaluated at the next IDLE.
- Field changes while a request is in flight are ignored: fields are captured at grant.
- Only one psel is ever high. psel and penable are never high in IDLE.
- Wait counter width is clog2(TIMEOUT); it is cleared on entry to SETUP.
- Reset mid-transfer: the next cycle is IDLE with all outputs 0. No done pulse is produced for the aborted transfer.

Test Plan:
1. Reset, then req0 write addr 0x005, wdata 0xA5A5A5A5, strb 1111; pready=1 → psel1=1 at t+1 (penable=0); penable=1 and pstrb=1111 at t+2; req0_done=1, req0_err=0 at t+3; psel2 never high.
2. req1 read addr 0x103; slave holds pready=0 for 2 ACCESS cycles, then pready=1 with prdata=0x12345678 → psel2=1; penable high 3 cycles; pstrb=0; req1_rdata=0x12345678 with req1_done; req1_rdata=0 the following cycle.
3. req0 and req1 both valid from reset, each re-asserting a new request after its done → grant order 0,1,0,1; no requester granted twice in a row; no transfer issued for a request in its done cycle.
4. Timeout: req0 read addr 0x010, pready held 0 → exactly 16 ACCESS cycles, then req0_done=1, req0_err=1, req0_rdata=0, FSM back in IDLE; a pending req1 is then serviced normally.
5. pslverr=1 with pready=1 on a req1 write to 0x1FF → req1_err=1 with req1_done; the following req0 transfer completes with err=0.
6. preset=1 during ACCESS of a req0 write → next cycle psel1=penable=0; no req0_done; with req0_valid still high after preset=0, the transfer restarts from SETUP.
